// File: rtl/uart_alu_ctrl.sv
// ---------------------------------------------------------------------------
// uart_alu_ctrl
//
// Frame controller between a UART receiver, an ALU and a UART transmitter.
// It collects a 3-byte command frame (operand A, operand B, opcode) from the
// receiver byte stream and presents it to the ALU on registered outputs.
// It then captures the ALU result and hands it to the transmitter through a
// start/done handshake. It aborts a frame whose next byte is late, and it
// flags bytes that arrive while a result is still in flight.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   rx_data      in   [N-1:0]    received byte, qualified by rx_valid
//   rx_valid     in   single-cycle pulse per received byte
//   alu_a        out  [N-1:0]    registered operand A
//   alu_b        out  [N-1:0]    registered operand B
//   alu_op       out  [OP_W-1:0] registered opcode (rx_data[OP_W-1:0])
//   alu_result   in   [N-1:0]    combinational ALU result
//   tx_data      out  [N-1:0]    registered byte for the transmitter
//   tx_start     out  single-cycle transmit request
//   tx_busy      in   transmitter currently sending
//   tx_done      in   single-cycle pulse, transmitter finished the byte
//   busy         out  high whenever the controller is not idle in WAIT_A
//   timeout_err  out  single-cycle pulse, frame aborted by inter-byte timeout
//   overrun_err  out  single-cycle pulse, byte dropped while not accepting
//
// Every output comes straight from a flop. The transmit decision is taken
// from the tx_busy value sampled at the same edge that raises tx_start.
// The request therefore appears in the cycle that follows the sampling edge.
// ---------------------------------------------------------------------------
module uart_alu_ctrl #(
  parameter int N              = 8,
  parameter int OP_W           = 6,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    rx_data,
  input  logic            rx_valid,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [N-1:0]    alu_result,
  output logic [N-1:0]    tx_data,
  output logic            tx_start,
  input  logic            tx_busy,
  input  logic            tx_done,
  output logic            busy,
  output logic            timeout_err,
  output logic            overrun_err
);

  localparam int            TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [N-1:0]    alu_a_q, alu_a_d;
  logic [N-1:0]    alu_b_q, alu_b_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic [N-1:0]    tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            busy_q, busy_d;
  logic            timeout_err_q, timeout_err_d;
  logic            overrun_err_q, overrun_err_d;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no
    // path can leave a signal unassigned and infer a latch.
    state_d       = state_q;
    timer_d       = timer_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;
    // The controller cannot accept a byte from EXEC until the result has
    // been sent, so any byte that arrives in that window is dropped.
    overrun_err_d = rx_valid &&
                    ((state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX));

    unique case (state_q)
      WAIT_A: begin
        timer_d = '0;
        if (rx_valid) begin
          alu_a_d = rx_data;
          state_d = WAIT_B;
        end
      end

      WAIT_B: begin
        // A byte that arrives on the terminal cycle is accepted and no
        // timeout is raised.
        if (rx_valid) begin
          alu_b_d = rx_data;
          timer_d = '0;
          state_d = WAIT_OP;
        end else if (timer_q == T_LAST) begin
          timeout_err_d = 1'b1;
          timer_d       = '0;
          state_d       = WAIT_A;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      WAIT_OP: begin
        if (rx_valid) begin
          alu_op_d = rx_data[OP_W-1:0];
          timer_d  = '0;
          state_d  = EXEC;
        end else if (timer_q == T_LAST) begin
          timeout_err_d = 1'b1;
          timer_d       = '0;
          state_d       = WAIT_A;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      EXEC: begin
        // The operands have been stable on the ALU for this whole cycle.
        tx_data_d = alu_result;
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = WAIT_TX;
        end else begin
          state_d = SEND;
        end
      end

      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = WAIT_TX;
        end
      end

      WAIT_TX: begin
        if (tx_done) begin
          state_d = WAIT_A;
        end
      end

      default: begin
        state_d = WAIT_A;
      end
    endcase

    busy_d = (state_d != WAIT_A);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before this clock edge.
    if (reset) begin
      state_q       <= WAIT_A;
      timer_q       <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_alu_ctrl
//
// Bench for uart_alu_ctrl with TIMEOUT_CYCLES=16 and a small behavioural
// ALU. Whenever an opcode byte is driven, the bench computes the expected
// result from the operands it sent and pushes it to a scoreboard queue. A
// negedge monitor pops the queue on each tx_start and compares it with
// tx_data. Inputs change 1 time unit after the rising edge. Outputs are
// sampled either at that same point or on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_alu_ctrl;

  localparam int N    = 8;
  localparam int OP_W = 6;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    rx_data;
  logic            rx_valid;
  logic [N-1:0]    alu_a, alu_b, alu_result, tx_data;
  logic [OP_W-1:0] alu_op;
  logic            tx_start, tx_busy, tx_done, busy, timeout_err, overrun_err;

  uart_alu_ctrl #(.N(N), .OP_W(OP_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU, also used to compute scoreboard entries.
  function automatic logic [N-1:0] alu_model(logic [N-1:0] a, logic [N-1:0] b,
                                             logic [OP_W-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_a, alu_b, alu_op);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and pulse monitor.
  logic [N-1:0] exp_q[$];
  int   n_start = 0;
  int   n_tout  = 0;
  int   n_ovr   = 0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    if (tx_start) begin
      n_start++;
      check("tx_start_gap", prev_start, 1'b0);
      check("sb_has_entry", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("tx_data", tx_data, exp_q.pop_front());
    end
    prev_start = tx_start;
    if (timeout_err) n_tout++;
    if (overrun_err) n_ovr++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(logic [N-1:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Sends a complete frame and queues the expected result.
  task automatic send_frame(logic [N-1:0] a, logic [N-1:0] b, logic [OP_W-1:0] op);
    send_byte(a);
    send_byte(b);
    exp_q.push_back(alu_model(a, b, op));
    send_byte({{(N-OP_W){1'b0}}, op});
  endtask

  // Waits a bounded number of cycles for tx_start.
  task automatic wait_start(string tag, int budget);
    int k = 0;
    while (!tx_start && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_start_seen"}, tx_start, 1'b1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_outs"},
          {alu_a, alu_b, 2'b00, alu_op, tx_data, tx_start, busy, timeout_err, overrun_err},
          32'h0);
  endtask

  int snap;

  initial begin
    reset    = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_vals("reset");

    // Basic add frame, idle transmitter.
    send_byte(8'h05);
    check("t1_alu_a", alu_a, 8'h05);
    check("t1_busy_rise", busy, 1'b1);
    send_byte(8'h03);
    check("t1_alu_b", alu_b, 8'h03);
    exp_q.push_back(8'h08);
    send_byte(8'h20);
    check("t1_alu_op", alu_op, 6'h20);
    check("t1_no_start_exec", tx_start, 1'b0);
    tick();
    check("t1_start_lat2", tx_start, 1'b1);
    check("t1_tx_data", tx_data, 8'h08);
    tick();
    check("t1_start_single", tx_start, 1'b0);
    pulse_done();
    check("t1_busy_fall", busy, 1'b0);

    // Timeout after operand A only.
    snap = n_tout;
    send_byte(8'h11);
    repeat (TO - 1) tick();
    check("t2_no_early_tout", timeout_err, 1'b0);
    tick();
    check("t2_tout_pulse", timeout_err, 1'b1);
    check("t2_busy_fall", busy, 1'b0);
    check("t2_alu_a_kept", alu_a, 8'h11);
    tick();
    check("t2_tout_single", n_tout - snap, 1);

    // Operand B arrives exactly on the terminal cycle.
    snap = n_tout;
    send_byte(8'h21);
    repeat (TO - 1) tick();
    send_byte(8'h0F);
    check("t3_b_accepted", alu_b, 8'h0F);
    check("t3_no_tout", timeout_err, 1'b0);
    exp_q.push_back(8'h12);
    send_byte(8'h22);
    wait_start("t3", 4);
    pulse_done();
    check("t3_tout_count", n_tout - snap, 0);

    // Transmitter busy for 10 cycles after EXEC.
    tx_busy = 1'b1;
    send_frame(8'h0C, 8'h0A, 6'h24);
    snap = n_start;
    repeat (10) tick();
    check("t4_start_withheld", n_start - snap, 0);
    tx_busy = 1'b0;
    tick();
    check("t4_start_after_idle", tx_start, 1'b1);
    tick();
    tick();
    check("t4_start_once", n_start - snap, 1);
    pulse_done();

    // Extra byte while waiting for tx_done.
    snap = n_ovr;
    send_frame(8'h30, 8'h12, 6'h25);
    wait_start("t5", 4);
    tick();
    send_byte(8'hAA);
    check("t5_overrun", overrun_err, 1'b1);
    check("t5_alu_a_kept", alu_a, 8'h30);
    tick();
    check("t5_overrun_once", n_ovr - snap, 1);
    pulse_done();
    check("t5_busy_fall", busy, 1'b0);
    send_byte(8'h44);
    check("t5_next_a", alu_a, 8'h44);

    // Reset while waiting for the opcode.
    send_byte(8'h01);
    reset = 1'b1;
    tick();
    check_reset_vals("t6_rst_waitop");
    reset = 1'b0;

    // Reset while holding in SEND; the withheld tx_start must never appear.
    snap    = n_start;
    tx_busy = 1'b1;
    send_byte(8'h07);
    send_byte(8'h08);
    send_byte(8'h20);
    tick();
    reset = 1'b1;
    tick();
    check_reset_vals("t6_rst_send");
    reset   = 1'b0;
    tx_busy = 1'b0;
    repeat (5) tick();
    check("t6_no_start", n_start - snap, 0);
    check("t6_idle", busy, 1'b0);

    // Final frame with 8-bit wraparound.
    send_frame(8'hFF, 8'h02, 6'h20);
    wait_start("t7", 4);
    pulse_done();
    check("t7_busy_fall", busy, 1'b0);

    tick();
    check("sb_drained", exp_q.size(), 0);
    check("total_starts", n_start, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
